// File: rtl/hack_mem_arbiter.sv
// hack_mem_arbiter
// Shares one single-port, synchronous-read data RAM between the CPU data
// port (fixed priority) and the screen scan-out reader (read-only).
//
// Build option: define ARB_STARVE_GUARD_EN to add the video starvation
// guard (wait counter + VID_FORCE state). Without it, video is granted only
// on cycles where the CPU does not request.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        CPU access request (held until granted)
//   cpu_gnt, cpu_stall           CPU issued this cycle / CPU waiting
//   cpu_rvalid, cpu_rdata        CPU read return (1 cycle after grant)
//   vid_req/addr                 video read request (held until granted)
//   vid_gnt                      video read issued this cycle
//   vid_rvalid, vid_rdata        video read return (1 cycle after grant)
//   ram_en/we/addr/wdata         RAM command port, follows the winner
//   ram_rdata                    RAM read data, valid the cycle after a read
module hack_mem_arbiter #(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned MAX_VID_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    if (MAX_VID_WAIT < 1 || MAX_VID_WAIT > 15) begin : g_bad_max_vid_wait
        $error("hack_mem_arbiter: MAX_VID_WAIT must be in 1..15");
    end

`ifdef ARB_STARVE_GUARD_EN
    typedef enum logic {
        CPU_PRI   = 1'b0,
        VID_FORCE = 1'b1
    } state_e;

    localparam logic [3:0] MAX_WAIT = 4'(MAX_VID_WAIT);

    state_e     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CPU_PRI;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic. The counter only advances in CPU_PRI; in VID_FORCE
    // it always clears (either video is granted or it dropped its request).
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!vid_req || vid_gnt) begin
            wait_cnt_d = '0;
        end else if (state_q == CPU_PRI && wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        state_d = CPU_PRI;
        unique case (state_q)
            CPU_PRI:   state_d = (wait_cnt_d == MAX_WAIT) ? VID_FORCE : CPU_PRI;
            VID_FORCE: state_d = CPU_PRI;
            default:   state_d = CPU_PRI;
        endcase
    end

    // Output logic: grants
    always_comb begin
        cpu_gnt = 1'b0;
        vid_gnt = 1'b0;
        if (!rst) begin
            unique case (state_q)
                CPU_PRI: begin
                    cpu_gnt = cpu_req;
                    vid_gnt = vid_req & ~cpu_req;
                end
                VID_FORCE: begin
                    vid_gnt = vid_req;
                    cpu_gnt = cpu_req & ~vid_req;
                end
                default: begin
                    cpu_gnt = 1'b0;
                    vid_gnt = 1'b0;
                end
            endcase
        end
    end
`else
    // Strict CPU priority: video only uses cycles the CPU leaves idle.
    always_comb begin
        cpu_gnt = cpu_req & ~rst;
        vid_gnt = vid_req & ~cpu_req & ~rst;
    end
`endif

    assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

    // RAM command mux; idle port drives zeros.
    always_comb begin
        ram_en    = cpu_gnt | vid_gnt;
        ram_we    = cpu_gnt & cpu_we;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (vid_gnt) begin
            ram_addr  = vid_addr;
        end
    end

    // Read-return tracking: {read issued, owner (1 = video)}.
    logic              rd_vld_q, rd_vid_q;
    logic [DATA_W-1:0] cpu_rdata_q, vid_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q    <= 1'b0;
            rd_vid_q    <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            rd_vld_q    <= ram_en & ~ram_we;
            rd_vid_q    <= vid_gnt;
            cpu_rdata_q <= cpu_rdata;
            vid_rdata_q <= vid_rdata;
        end
    end

    // A read issued just before reset must not return while rst is high,
    // so the return strobes and data are masked by rst directly.
    always_comb begin
        cpu_rvalid = rd_vld_q & ~rd_vid_q & ~rst;
        vid_rvalid = rd_vld_q &  rd_vid_q & ~rst;
        cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_q;
        vid_rdata  = vid_rvalid ? ram_rdata : vid_rdata_q;
        if (rst) begin
            cpu_rdata = '0;
            vid_rdata = '0;
        end
    end

endmodule

// File: tb/tb_hack_mem_arbiter.sv
module tb_hack_mem_arbiter;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_stall, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt, vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    hack_mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_VID_WAIT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_stall (cpu_stall),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_gnt   (vid_gnt),
        .vid_rvalid(vid_rvalid),
        .vid_rdata (vid_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read single-port RAM
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; vid_req = 1'b0;
        sample();
        check("wr_gnt", {31'd0, cpu_gnt}, 32'd1);
        check("wr_ram_we", {31'd0, ram_we}, 32'd1);
        check("wr_ram_wdata", {16'd0, ram_wdata}, {16'd0, d});
        check("wr_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requests held
        rst = 1'b1; cpu_req = 1'b1; vid_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 15'h0010; cpu_wdata = 16'h1234; vid_addr = 15'h4000;
        sample();
        check("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        check("rst_vid_gnt", {31'd0, vid_gnt}, 32'd0);
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_ram_addr", {17'd0, ram_addr}, 32'd0);
        check("rst_rvalids", {30'd0, cpu_rvalid, vid_rvalid}, 32'd0);
        check("rst_rdatas", {cpu_rdata, vid_rdata}, 32'd0);

        // First post-reset cycle: CPU write 0x1234 -> 0x0010, video waiting
        next_cycle();
        rst = 1'b0;
        sample();
        check("post_rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        check("post_rst_vid_gnt", {31'd0, vid_gnt}, 32'd0);
        check("post_rst_ram_we", {31'd0, ram_we}, 32'd1);
        check("post_rst_ram_addr", {17'd0, ram_addr}, 32'h0010);
        check("post_rst_wdata", {16'd0, ram_wdata}, 32'h1234);
        check("post_rst_stall", {31'd0, cpu_stall}, 32'd0);

        // Preload for the alternating-read test
        cpu_write(15'h0001, 16'hAAAA);
        cpu_write(15'h4001, 16'h5555);
        cpu_write(15'h0002, 16'hBBBB);

        // CPU read of 0x0010
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
        sample();
        check("rd_gnt", {31'd0, cpu_gnt}, 32'd1);
        check("rd_ram_we", {31'd0, ram_we}, 32'd0);
        check("rd_stall", {31'd0, cpu_stall}, 32'd0);
        check("rd_no_rvalid_yet", {31'd0, cpu_rvalid}, 32'd0);
        next_cycle();
        cpu_req = 1'b0;
        sample();
        check("rd_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("rd_rdata", {16'd0, cpu_rdata}, 32'h1234);
        check("rd_vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
        check("idle_ram_en", {31'd0, ram_en}, 32'd0);
        check("idle_ram_addr", {17'd0, ram_addr}, 32'd0);

        // Alternating reads CPU 0x0001, video 0x4001, CPU 0x0002
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 15'h0001; vid_req = 1'b0;
        sample();
        check("alt_a_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        next_cycle();
        cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 15'h4001;
        sample();
        check("alt_b_vid_gnt", {31'd0, vid_gnt}, 32'd1);
        check("alt_b_ram_addr", {17'd0, ram_addr}, 32'h4001);
        check("alt_b_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("alt_b_cpu_rdata", {16'd0, cpu_rdata}, 32'hAAAA);
        check("alt_b_vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 15'h0002; vid_req = 1'b0;
        sample();
        check("alt_c_vid_rvalid", {31'd0, vid_rvalid}, 32'd1);
        check("alt_c_vid_rdata", {16'd0, vid_rdata}, 32'h5555);
        check("alt_c_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("alt_c_cpu_rdata_hold", {16'd0, cpu_rdata}, 32'hAAAA);
        next_cycle();
        cpu_req = 1'b0;
        sample();
        check("alt_d_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("alt_d_cpu_rdata", {16'd0, cpu_rdata}, 32'hBBBB);
        check("alt_d_vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
        check("alt_d_vid_rdata_hold", {16'd0, vid_rdata}, 32'h5555);

        // Continuous CPU load with a waiting video reader
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0020;
            vid_req = 1'b1; vid_addr = 15'h4000;
            sample();
            check("starve_vid_gnt", {31'd0, vid_gnt}, {31'd0, GUARD && (k % 5 == 0)});
            check("starve_stall", {31'd0, cpu_stall}, {31'd0, GUARD && (k % 5 == 0)});
            check("starve_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, !(GUARD && (k % 5 == 0))});
        end
        next_cycle();
        cpu_req = 1'b0;
        sample();
        check("starve_release_gnt", {31'd0, vid_gnt}, 32'd1);
        check("starve_release_addr", {17'd0, ram_addr}, 32'h4000);

        // Video drops its request in the forced slot
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            cpu_req = 1'b1; vid_req = (k != 5);
            sample();
            check("drop_vid_gnt", {31'd0, vid_gnt}, {31'd0, GUARD && (k == 10)});
            check("drop_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, !(GUARD && (k == 10))});
        end

        // Read issued just before reset: its return is suppressed
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010; vid_req = 1'b0;
        sample();
        check("prerst_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        next_cycle();
        rst = 1'b1; vid_req = 1'b1;
        sample();
        check("midrst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("midrst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        check("midrst_gnts", {30'd0, cpu_gnt, vid_gnt}, 32'd0);
        check("midrst_stall", {31'd0, cpu_stall}, 32'd0);
        next_cycle();
        rst = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
        sample();
        check("postrst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("postrst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        check("postrst_vid_rdata", {16'd0, vid_rdata}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
